// File: rtl/window_gen_3x3.sv
// window_gen_3x3: turns a raster-order pixel stream into one zero-padded 3x3
// neighbourhood per pixel, in raster order, using two line buffers and a 3x3
// shift register. Border padding is applied when the output register loads.
module window_gen_3x3 #(
    parameter int unsigned IMG_W = 1024,
    parameter int unsigned IMG_H = 1024,
    parameter int unsigned DW    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   s_data,
    input  logic            s_valid,
    input  logic            s_last,
    output logic            s_ready,
    output logic [9*DW-1:0] m_win,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            m_last,
    output logic            frame_err
);

    localparam int unsigned   XW   = $clog2(IMG_W);
    localparam int unsigned   YW   = $clog2(IMG_H);
    localparam logic [XW-1:0] XMax = XW'(IMG_W - 1);
    localparam logic [YW-1:0] YMax = YW'(IMG_H - 1);

    localparam logic [1:0] StFill  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StFlush = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [XW-1:0]   in_x_q, in_x_d, out_x_q, out_x_d;
    logic [YW-1:0]   in_y_q, in_y_d, out_y_q, out_y_d;
    logic [DW-1:0]   sr_q [3][3];
    logic [DW-1:0]   sr_d [3][3];
    logic [9*DW-1:0] win_q, win_d, win_load;
    logic            valid_q, valid_d, last_q, last_d, err_q, err_d;
    logic [DW-1:0]   lb0_q [IMG_W];  // previous line
    logic [DW-1:0]   lb1_q [IMG_W];  // line before that

    logic          accept, flush_adv, advance, load;
    logic          in_end, out_end, emit_last;
    logic [DW-1:0] pix;

    assign accept    = s_valid && s_ready;
    // Zero pixels are injected after the frame to push out the last two rows.
    assign flush_adv = (state_q == StFlush) && (!valid_q || m_ready) && !last_q;
    assign advance   = accept || flush_adv;
    // Window k loads when pixel k+IMG_W+1 enters, i.e. on every RUN accept.
    assign load      = flush_adv || (accept && (state_q == StRun));
    assign in_end    = (in_x_q == XMax) && (in_y_q == YMax);
    assign out_end   = (out_x_q == XMax) && (out_y_q == YMax);
    assign emit_last = valid_q && last_q && m_ready;
    assign pix       = (state_q == StFlush) ? '0 : s_data;

    assign m_win     = win_q;
    assign m_valid   = valid_q;
    assign m_last    = last_q;
    assign frame_err = err_q;

    // Input-side ready depends on state and on output back-pressure.
    always_comb begin
        s_ready = 1'b0;
        if (!rst) begin
            case (state_q)
                StFill:  s_ready = 1'b1;
                StRun:   s_ready = !valid_q || m_ready;
                default: s_ready = 1'b0;
            endcase
        end
    end

    // Shift the window left and bring in the new column {two up, one up, new}.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            sr_d[r][0] = sr_q[r][1];
            sr_d[r][1] = sr_q[r][2];
        end
        sr_d[0][2] = lb1_q[in_x_q];
        sr_d[1][2] = lb0_q[in_x_q];
        sr_d[2][2] = pix;
    end

    // Zero the rows/columns that fall outside the frame for the centre pixel.
    always_comb begin
        win_load = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!((r == 0 && out_y_q == '0) || (r == 2 && out_y_q == YMax) ||
                      (c == 0 && out_x_q == '0) || (c == 2 && out_x_q == XMax))) begin
                    win_load[DW*(3*r+c) +: DW] = sr_d[r][c];
                end
            end
        end
    end

    // Counters, output register, error flag and FILL/RUN/FLUSH sequencing.
    always_comb begin
        state_d = state_q;
        in_x_d  = in_x_q;
        in_y_d  = in_y_q;
        out_x_d = out_x_q;
        out_y_d = out_y_q;
        valid_d = valid_q;
        last_d  = last_q;
        win_d   = win_q;
        err_d   = err_q;

        if (accept && (s_last != in_end)) err_d = 1'b1;

        if (advance) begin
            in_x_d = (in_x_q == XMax) ? '0 : in_x_q + 1'b1;
            if (in_x_q == XMax) in_y_d = (in_y_q == YMax) ? '0 : in_y_q + 1'b1;
        end

        if (load) begin
            valid_d = 1'b1;
            last_d  = out_end;
            win_d   = win_load;
            out_x_d = (out_x_q == XMax) ? '0 : out_x_q + 1'b1;
            if (out_x_q == XMax) out_y_d = (out_y_q == YMax) ? '0 : out_y_q + 1'b1;
        end else if (m_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        case (state_q)
            StFill:  if (accept && in_x_q == '0 && in_y_q == YW'(1)) state_d = StRun;
            StRun:   if (accept && in_end) state_d = StFlush;
            StFlush: begin
                if (emit_last) begin
                    state_d = StFill;
                    in_x_d  = '0;
                    in_y_d  = '0;
                end
            end
            default: state_d = StFill;
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFill;
            in_x_q  <= '0;
            in_y_q  <= '0;
            out_x_q <= '0;
            out_y_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            win_q   <= '0;
            err_q   <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) sr_q[r][c] <= '0;
            end
        end else begin
            state_q <= state_d;
            in_x_q  <= in_x_d;
            in_y_q  <= in_y_d;
            out_x_q <= out_x_d;
            out_y_q <= out_y_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            win_q   <= win_d;
            err_q   <= err_d;
            if (advance) sr_q <= sr_d;
        end
    end

    // Line buffers: stale contents are always masked, so no reset is needed.
    always_ff @(posedge clk) begin
        if (advance) begin
            lb1_q[in_x_q] <= lb0_q[in_x_q];
            lb0_q[in_x_q] <= pix;
        end
    end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Self-checking bench for window_gen_3x3: a zero-padded 3x3 reference computed
// directly from the frame image, checked on every emitted window, plus
// hand-computed windows for the small directed frames.
module tb_window_gen_3x3;

    localparam int W     = 4;
    localparam int H     = 3;
    localparam int DW    = 8;
    localparam int N     = W * H;
    localparam int NR    = 15;
    localparam int GUARD = 6000;

    logic            clk;
    logic            rst;
    logic [DW-1:0]   s_data;
    logic            s_valid;
    logic            s_last;
    logic            s_ready;
    logic [9*DW-1:0] m_win;
    logic            m_valid;
    logic            m_ready;
    logic            m_last;
    logic            frame_err;

    window_gen_3x3 #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .m_win    (m_win),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int              n_checks = 0;
    int              n_errors = 0;
    logic [DW-1:0]   img [0:255];
    int              win_cnt;
    int              acc_total;
    int              first_acc;
    logic [9*DW-1:0] cap_win [0:63];
    int              cap_last [0:63];
    bit              hold_chk = 1'b0;
    logic [9*DW-1:0] hold_win;
    int              hold_last;

    task automatic check_win(input string name, input logic [9*DW-1:0] act,
                             input logic [9*DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [9*DW-1:0] pack9(input int a0, input int a1, input int a2,
                                              input int a3, input int a4, input int a5,
                                              input int a6, input int a7, input int a8);
        int v [9];
        logic [9*DW-1:0] w;
        v = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
        w = '0;
        for (int i = 0; i < 9; i++) w[DW*i +: DW] = DW'(v[i]);
        return w;
    endfunction

    // Neighbourhood of pixel k of the frame starting at img[base]; outside -> 0.
    function automatic logic [9*DW-1:0] model_win(input int base, input int k);
        logic [9*DW-1:0] w;
        int y, x, r, c;
        w = '0;
        y = k / W;
        x = k % W;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                r = y - 1 + i;
                c = x - 1 + j;
                if (r >= 0 && r < H && c >= 0 && c < W) w[DW*(3*i+j) +: DW] = img[base + r*W + c];
            end
        end
        return w;
    endfunction

    task automatic load_ramp(input int frame, input int first_val);
        for (int i = 0; i < N; i++) img[frame*N + i] = DW'(first_val + i);
    endtask

    // Compare process: every emitted window against the model; stalls must hold.
    always @(negedge clk) begin
        if (rst) begin
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                check_int("hold_valid", int'(m_valid), 1);
                check_win("hold_win", m_win, hold_win);
                check_int("hold_last", int'(m_last), hold_last);
            end
            hold_chk  = m_valid && !m_ready;
            hold_win  = m_win;
            hold_last = int'(m_last);
            if (m_valid && first_acc < 0) first_acc = acc_total;
            if (m_valid && m_ready) begin
                check_win($sformatf("win%0d", win_cnt), m_win,
                          model_win((win_cnt / N) * N, win_cnt % N));
                check_int($sformatf("last%0d", win_cnt), int'(m_last),
                          int'((win_cnt % N) == N - 1));
                if (win_cnt < 64) begin
                    cap_win[win_cnt]  = m_win;
                    cap_last[win_cnt] = int'(m_last);
                end
                win_cnt++;
            end
        end
    end

    // Feed npix pixels from img and wait for nwin windows (nwin<0: don't wait).
    task automatic run(input int npix, input int nwin, input int vpct, input int rpct,
                       input int stall_k, input int err_idx);
        int  i;
        int  guard;
        int  stall_left;
        bit  stalled;
        bit  acc;
        bit  err_seen;
        i = 0; guard = 0; stall_left = 0; stalled = 1'b0; err_seen = 1'b0;
        while ((i < npix || (nwin >= 0 && win_cnt < nwin)) && guard < GUARD) begin
            s_valid = (i < npix) && (int'($urandom_range(99)) < vpct);
            s_data  = (i < npix) ? img[i] : '0;
            s_last  = (i < npix) && (((i % N) == N - 1) || (i == err_idx));
            if (!stalled && stall_k >= 0 && m_valid && win_cnt == stall_k) begin
                stalled    = 1'b1;
                stall_left = 3;
            end
            m_ready = (stall_left == 0) && (int'($urandom_range(99)) < rpct);
            @(negedge clk);
            if (stall_left > 0) begin
                check_int("stall_s_ready", int'(s_ready), 0);
                stall_left--;
            end
            if (err_seen) check_int("frame_err_sticky", int'(frame_err), 1);
            acc = s_valid && s_ready;
            if (acc && i == err_idx) err_seen = 1'b1;
            @(posedge clk);
            #1;
            if (acc) begin
                i++;
                acc_total++;
            end
            guard++;
        end
        if (guard >= GUARD) begin
            n_checks++;
            n_errors++;
            $display("FAIL run_timeout: accepted %0d of %0d, windows %0d of %0d",
                     i, npix, win_cnt, nwin);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic start_phase();
        win_cnt   = 0;
        acc_total = 0;
        first_acc = -1;
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
        start_phase();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_int("rst_s_ready", int'(s_ready), 0);
        check_int("rst_m_valid", int'(m_valid), 0);
        check_win("rst_m_win", m_win, '0);
        check_int("rst_m_last", int'(m_last), 0);
        check_int("rst_frame_err", int'(frame_err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed frame, full throughput.
        load_ramp(0, 1);
        start_phase();
        run(N, N, 100, 100, -1, -1);
        check_int("first_valid_after_accepts", first_acc, W + 2);
        check_int("count_frame", win_cnt, N);
        check_win("win_0_0", cap_win[0], pack9(0, 0, 0, 0, 1, 2, 0, 5, 6));
        check_win("win_1_1", cap_win[5], pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));
        check_win("win_2_3", cap_win[11], pack9(7, 8, 0, 11, 12, 0, 0, 0, 0));
        check_int("win_2_3_last", cap_last[11], 1);
        check_int("frame_err_clean", int'(frame_err), 0);

        // Stall for 3 cycles while window (1,0) is presented.
        start_phase();
        run(N, N, 100, 100, 4, -1);
        check_win("win_1_0_stalled", cap_win[4], pack9(0, 1, 2, 0, 5, 6, 0, 9, 10));
        check_int("count_stall", win_cnt, N);

        // Two back-to-back frames.
        load_ramp(0, 1);
        load_ramp(1, 101);
        start_phase();
        run(2 * N, 2 * N, 100, 100, -1, -1);
        check_int("count_b2b", win_cnt, 2 * N);
        check_int("b2b_last_11", cap_last[11], 1);
        check_int("b2b_last_10", cap_last[10], 0);
        check_int("b2b_last_23", cap_last[23], 1);
        check_win("b2b_f2_win_0_0", cap_win[12], pack9(0, 0, 0, 0, 101, 102, 0, 105, 106));

        // Random pixels, random valid and ready.
        for (int i = 0; i < NR * N; i++) img[i] = DW'($urandom);
        start_phase();
        run(NR * N, NR * N, 50, 50, -1, -1);
        check_int("count_random", win_cnt, NR * N);
        check_int("frame_err_random", int'(frame_err), 0);

        // Spurious s_last on pixel 7.
        load_ramp(0, 1);
        start_phase();
        run(N, N, 100, 100, -1, 7);
        check_int("frame_err_set", int'(frame_err), 1);
        check_int("count_err", win_cnt, N);
        check_win("err_win_1_1", cap_win[5], pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));

        // Reset after 8 accepts, then a clean frame.
        start_phase();
        run(8, -1, 100, 100, -1, -1);
        rst     = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        check_int("midrst_s_ready", int'(s_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        check_int("midrst_m_valid", int'(m_valid), 0);
        check_int("midrst_frame_err", int'(frame_err), 0);
        @(posedge clk);
        #1;
        start_phase();
        run(N, N, 100, 100, -1, -1);
        check_int("count_after_rst", win_cnt, N);
        check_win("rst_win_0_0", cap_win[0], pack9(0, 0, 0, 0, 1, 2, 0, 5, 6));
        check_win("rst_win_2_3", cap_win[11], pack9(7, 8, 0, 11, 12, 0, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
